// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient}.
// Optional DIV_ZERO_FAST_EN: a zero divisor short-circuits through BYZERO in two cycles.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o
);

    localparam int CW = $clog2(WIDTH) + 1;

`ifdef DIV_ZERO_FAST_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, END = 2'd2, BYZERO = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, END = 2'd2} state_t;
`endif

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;      // dividend magnitude, consumed MSB first
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic             neg_a;    // signed op with negative dividend
    logic             neg_b;    // signed op with negative divisor

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign stall_o = start_i & ~ready_o;

    // Borrow lands in bit WIDTH because the partial remainder is always below 2*divisor.
    always_comb begin
        shifted = {rem, dvd[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        borrow  = diff[WIDTH];
        rem_nxt = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], ~borrow};
        q_fix   = (neg_a ^ neg_b) ? -quo_nxt : quo_nxt;
        r_fix   = neg_a ? -rem_nxt : rem_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && !annul_i) begin
                        neg_a <= signed_i & opdata1_i[WIDTH-1];
                        neg_b <= signed_i & opdata2_i[WIDTH-1];
                        dvd   <= (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
                        dvs   <= (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
                        rem   <= '0;
                        quo   <= '0;
                        cnt   <= '0;
`ifdef DIV_ZERO_FAST_EN
                        state <= (opdata2_i == '0) ? BYZERO : ON;
`else
                        state <= ON;
`endif
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        dvd <= {dvd[WIDTH-2:0], 1'b0};
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) begin
                            state    <= END;
                            result_o <= {r_fix, q_fix};
                            ready_o  <= 1'b1;
                        end
                    end
                end
`ifdef DIV_ZERO_FAST_EN
                BYZERO: begin
                    if (annul_i) begin
                        state <= IDLE;
                    end else begin
                        // re-negating the stored magnitude recovers the raw dividend
                        state    <= END;
                        result_o <= {(neg_a ? -dvd : dvd), {WIDTH{1'b1}}};
                        ready_o  <= 1'b1;
                    end
                end
`endif
                END: begin
                    if (annul_i || !start_i) begin
                        state    <= IDLE;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed + randomized bench for div_seq against an arithmetic reference model.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall;

    int ntests = 0;
    int nfail  = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 33;
`endif

    div_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start), .signed_i(sgn),
        .opdata1_i(op1), .opdata2_i(op2), .annul_i(annul),
        .result_o(result), .ready_o(ready), .stall_o(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) begin
`ifdef DIV_ZERO_FAST_EN
            q = 32'hFFFF_FFFF;
`else
            q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
`endif
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
        end
        return {r, q};
    endfunction

    // Launch, count edges to ready, scramble operands while busy, then release.
    task automatic do_div(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input bit end_annul);
        logic [63:0] exp;
        int lat, hold, elat;
        bit stall_ok;
        exp  = ref_div(s, a, b);
        elat = (b == 32'd0) ? ZLAT : 33;
        lat = 0;
        stall_ok = 1'b1;
        @(negedge clk);
        start = 1'b1; sgn = s; op1 = a; op2 = b;
        #1;
        if (stall !== 1'b1) stall_ok = 1'b0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            op1 = $urandom; op2 = $urandom; sgn = 1'($urandom_range(0, 1));
            if (ready === 1'b1) break;
            if (stall !== 1'b1) stall_ok = 1'b0;
        end
        chk({tag, " latency"}, 64'(lat), 64'(elat));
        chk({tag, " result"}, result, exp);
        chk({tag, " stall"}, 64'(stall_ok), 64'd1);
        hold = $urandom_range(0, 2);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        chk({tag, " held"}, {result[62:0], ready}, {exp[62:0], 1'b1});
        @(negedge clk);
        if (end_annul) annul = 1'b1;
        else start = 1'b0;
        @(posedge clk); #1;
        chk({tag, " release"}, {result, ready}, 65'd0);
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
    endtask

    initial begin
        int lat;
        bit seen;
        logic s;
        logic [31:0] a, b;

        rst = 1'b1; start = 1'b1; sgn = 1'b0; op1 = 32'd100; op2 = 32'd7; annul = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset state", {result, ready, stall}, {64'd0, 1'b0, 1'b1});
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("reset stall low", 64'(stall), 64'd0);
        rst = 1'b0;

        do_div("divu 100/7", 1'b0, 32'd100, 32'd7, 1'b0);
        do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);
        do_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_div("divu 5/0", 1'b0, 32'd5, 32'd0, 1'b0);
        do_div("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);
        do_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);

        // annul mid-division
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; op1 = 32'd1000; op2 = 32'd3;
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        chk("annul on", {result, ready}, 65'd0);
        @(negedge clk);
        annul = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready !== 1'b0 || result !== 64'd0) seen = 1'b1;
        end
        chk("annul quiet", 64'(seen), 64'd0);
        do_div("divu 9/3", 1'b0, 32'd9, 32'd3, 1'b0);

        // start together with annul in IDLE is ignored
        @(negedge clk);
        start = 1'b1; annul = 1'b1;
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready !== 1'b0) seen = 1'b1;
        end
        chk("idle annul ignored", 64'(seen), 64'd0);

        // synchronous reset mid-division with start held, then relaunch
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; op1 = 32'd1234567; op2 = 32'd89;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst mid", {result, ready}, 65'd0);
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (ready === 1'b1) break;
        end
        chk("rst relaunch latency", 64'(lat), 64'd33);
        chk("rst relaunch result", result, ref_div(1'b0, 32'd1234567, 32'd89));
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk("rst relaunch release", {result, ready}, 65'd0);

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom_range(1, 20);
                2: b = 32'hFFFF_FFFF - $urandom_range(0, 15);
                default: b = a >> $urandom_range(0, 31);
            endcase
            do_div($sformatf("rand%0d", i), s, a, b, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle sequencer for the EX-stage divide resource, serving the `EXE_DIV_OP` and `EXE_DIVU_OP` ops that the single-cycle ALU cannot complete. It accepts one request from the execute stage and latches its operands. It runs a radix-2 restoring division, one quotient bit per cycle, and returns the 64-bit {remainder, quotient} result for the HI/LO write. While busy it drives a stall request so the pipeline holds the dividing instruction in EX.

## Interface
Parameters:
- `WIDTH`, 32: operand width; the counter and result widths derive from it.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  divide request; held high by EX until `ready_o` is seen.
- `signed_i`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i`  in  WIDTH  dividend.
- `opdata2_i`  in  WIDTH  divisor.
- `annul_i`  in  1  flush; aborts a running division.
- `result_o`  out  2*WIDTH  {remainder[63:32] → HI, quotient[31:0] → LO}.
- `ready_o`  out  1  result valid.
- `stall_o`  out  1  combinational `start_i & ~ready_o`; pipeline stall request.

## Operation
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - `start_i & ~annul_i`: latch operands and `signed_i`.
  - Signed and operand negative: store its magnitude (two's-complement negate).
  - Clear counter; go to ON. With `DIV_ZERO_FAST_EN`, a divisor of 0 goes to BYZERO instead.
  - `start_i & annul_i`: ignored; stay in IDLE.
- ON, one iteration per cycle:
  - Shift the partial remainder left 1 and bring in the next dividend bit, MSB first.
  - Trial subtract the divisor magnitude. If there is no borrow, keep the difference and set quotient bit = 1. Otherwise keep the shifted value and set quotient bit = 0.
  - After iteration 32 (counter == WIDTH), go to END.
  - Trial-subtract width is WIDTH+1 bits; the borrow is bit WIDTH.
- END:
  - Apply sign fixups, signed only. Negate the quotient if the dividend and divisor signs differ. Negate the remainder if the dividend was negative.
  - Register `result_o`; `ready_o` = 1.
  - Hold while `start_i` = 1; go to IDLE on the first cycle `start_i` = 0.
- BYZERO (only with macro): one cycle, then END with quotient = 0xFFFFFFFF and remainder = raw latched dividend. No sign fixups.
- `annul_i` = 1 in ON or BYZERO: go to IDLE next edge, `ready_o` stays 0, `result_o` 0. `annul_i` in END: go to IDLE, `ready_o` drops.
- Input operand changes after the start edge have no effect.
- 0x80000000 / −1 (signed): result is quotient 0x80000000, remainder 0. No trap; overflow is not reported.

## Timing
- Reset values: state IDLE, counter 0, `result_o` 0, `ready_o` 0. `stall_o` follows `start_i`.
- `rst` overrides every state, including mid-division, and wins over `start_i` in the same cycle.
- Start sampled at edge T: ON covers T+1..T+32; END entered at T+33.
- `result_o` and `ready_o` are valid from T+33; latency is 33 cycles.
- BYZERO path: BYZERO at T+1, END at T+2.
- `result_o` is stable for the whole END residency.
- It returns to 0 on leaving END, so there is no stale data in IDLE.
- Back-to-back requests:
  - `start_i` must drop for at least one cycle between requests, because END waits for it to fall.
  - A new start is accepted in IDLE on the cycle after that.

## Configuration
- `DIV_ZERO_FAST_EN` defined:
  - A divisor of 0 takes the BYZERO path and completes in 2 cycles.
  - Result is quotient 0xFFFFFFFF, remainder = raw dividend.
- `DIV_ZERO_FAST_EN` undefined: BYZERO state is absent. A divisor of 0 runs the full 33-cycle ON path, and the result is whatever the iteration and the normal sign fixups produce.
  - DIVU: quotient 0xFFFFFFFF, remainder = dividend.
  - DIV: quotient 1 if the dividend is negative, else 0xFFFFFFFF; remainder = dividend.

## Test plan
- DIVU 100 / 7, start at edge T: `ready_o` rises exactly at T+33; `result_o` = {0x00000002, 0x0000000E}; `stall_o` is 1 from T through T+32.
- DIV −7 / 2 (0xFFFFFFF9, 0x00000002): `result_o` = {0xFFFFFFFF, 0xFFFFFFFD}. DIV 7 / −2: {0x00000001, 0xFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF: `result_o` = {0x00000000, 0x80000000}, with no other indication.
- Annul at T+10:
  - FSM returns to IDLE at T+11; `ready_o` never rises; `result_o` stays 0.
  - A new DIVU 9 / 3 started at T+12 yields {0, 3} at T+45.
- Divisor 0 (DIVU 5 / 0):
  - With `DIV_ZERO_FAST_EN`: `ready_o` at T+2, result {0x00000005, 0xFFFFFFFF}.
  - Without the macro: same value at T+33.
- `rst` = 1 at T+20 with `start_i` still high: the next edge is IDLE with `ready_o` = 0 and `result_o` = 0. After `rst` drops, a held `start_i` relaunches with `ready_o` 33 cycles later.
